// File: rtl/sii_dmu_inbound_rx.sv
// sii_dmu_inbound_rx
//   SII-side receive stage for the DMU->SII inbound interface. Decodes header
//   and payload cycles, checks per-16-bit parity, and emits a registered,
//   framed packet stream (one cycle latency) to the ordered/bypass queue logic.
//   Returns write-ack credits to the DMU and keeps saturating error counters.
//
// Ports
//   iol2clk, rst_l                 clock, asynchronous active-low reset
//   dmu_sii_hdr_vld                header cycle valid
//   dmu_sii_reqbypass              1 = bypass queue, 0 = ordered queue
//   dmu_sii_datareq/_datareq16     packet class (payload / 16B mondo-PIO)
//   dmu_sii_data/_parity/_be       beat data, per-16-bit parity, byte enables
//   pkt_*                          framed output beat (vld/sop/eop/type/...)
//   sii_dmu_wrack_vld/_tag         write-ack pulse and tag
//   proto_err                      one-cycle protocol violation pulse
//   perr_cnt, proto_err_cnt        saturating error counters

module sii_dmu_inbound_rx #(
  parameter int unsigned WR_BEATS = 4,
  parameter int unsigned MP_BEATS = 1,
  parameter int unsigned TAG_LSB  = 64,
  parameter int unsigned ERRCNT_W = 16
) (
  input  logic                iol2clk,
  input  logic                rst_l,
  input  logic                dmu_sii_hdr_vld,
  input  logic                dmu_sii_reqbypass,
  input  logic                dmu_sii_datareq,
  input  logic                dmu_sii_datareq16,
  input  logic [127:0]        dmu_sii_data,
  input  logic [7:0]          dmu_sii_parity,
  input  logic [15:0]         dmu_sii_be,
  output logic                pkt_vld,
  output logic                pkt_sop,
  output logic                pkt_eop,
  output logic [1:0]          pkt_type,
  output logic                pkt_bypass,
  output logic [127:0]        pkt_data,
  output logic [15:0]         pkt_be,
  output logic                pkt_perr,
  output logic                sii_dmu_wrack_vld,
  output logic [3:0]          sii_dmu_wrack_tag,
  output logic                proto_err,
  output logic [ERRCNT_W-1:0] perr_cnt,
  output logic [ERRCNT_W-1:0] proto_err_cnt
);

  localparam logic [1:0] TypeRead  = 2'b00;
  localparam logic [1:0] TypeWrite = 2'b01;

  typedef enum logic [1:0] {StIdle, StWpay, StMpay} state_e;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [3:0]          tag_q, tag_d;
  logic [1:0]          type_q, type_d;
  logic                bypass_q, bypass_d;

  logic                vld_q, vld_d;
  logic                sop_q, sop_d;
  logic                eop_q, eop_d;
  logic [1:0]          ptype_q, ptype_d;
  logic                pbyp_q, pbyp_d;
  logic [127:0]        data_q, data_d;
  logic [15:0]         be_q, be_d;
  logic                perr_q, perr_d;
  logic                ack_q, ack_d;
  logic [3:0]          ack_tag_q, ack_tag_d;
  logic                proto_q, proto_d;
  logic [ERRCNT_W-1:0] perr_cnt_q, perr_cnt_d;
  logic [ERRCNT_W-1:0] proto_cnt_q, proto_cnt_d;

  logic                perr_c;

  always_comb begin
    perr_c = 1'b0;
    for (int i = 0; i < 8; i++) begin
      perr_c = perr_c | (dmu_sii_parity[i] != ^dmu_sii_data[16*i +: 16]);
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    tag_d    = tag_q;
    type_d   = type_q;
    bypass_d = bypass_q;
    vld_d    = 1'b0;
    sop_d    = 1'b0;
    eop_d    = 1'b0;
    ptype_d  = 2'b00;
    pbyp_d   = 1'b0;
    data_d   = '0;
    be_d     = '0;
    perr_d   = 1'b0;
    proto_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (dmu_sii_hdr_vld) begin
          unique case ({dmu_sii_datareq, dmu_sii_datareq16})
            2'b00: begin
              ptype_d = TypeRead;
              eop_d   = 1'b1;
            end
            2'b10: begin
              ptype_d = TypeWrite;
              tag_d   = dmu_sii_data[TAG_LSB +: 4];
              cnt_d   = 4'(WR_BEATS);
              state_d = StWpay;
            end
            2'b11: begin
              ptype_d = {1'b1, dmu_sii_reqbypass};
              cnt_d   = 4'(MP_BEATS);
              state_d = StMpay;
            end
            default: proto_d = 1'b1;
          endcase
          // Illegal class produces no beat; everything else emits the header.
          if (!proto_d) begin
            vld_d    = 1'b1;
            sop_d    = 1'b1;
            pbyp_d   = dmu_sii_reqbypass;
            data_d   = dmu_sii_data;
            be_d     = '1;
            perr_d   = perr_c;
            type_d   = ptype_d;
            bypass_d = dmu_sii_reqbypass;
          end
        end
      end
      StWpay, StMpay: begin
        // Payload is back-to-back: every cycle here is a beat, even if the
        // DMU wrongly raises hdr_vld (flagged, not decoded).
        proto_d = dmu_sii_hdr_vld;
        vld_d   = 1'b1;
        ptype_d = type_q;
        pbyp_d  = bypass_q;
        data_d  = dmu_sii_data;
        be_d    = (state_q == StMpay) ? '1 : dmu_sii_be;
        perr_d  = perr_c;
        cnt_d   = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          eop_d   = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Ack follows the registered eop of a write. tag_q still holds the finished
  // packet's tag here even if a new write header is being accepted this cycle.
  always_comb begin
    ack_d     = vld_q & eop_q & (ptype_q == TypeWrite);
    ack_tag_d = ack_d ? tag_q : 4'd0;
  end

  always_comb begin
    perr_cnt_d  = perr_cnt_q;
    proto_cnt_d = proto_cnt_q;
    if (vld_d && perr_d && (perr_cnt_q != '1)) begin
      perr_cnt_d = perr_cnt_q + ERRCNT_W'(1);
    end
    if (proto_d && (proto_cnt_q != '1)) begin
      proto_cnt_d = proto_cnt_q + ERRCNT_W'(1);
    end
  end

  always_ff @(posedge iol2clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q     <= StIdle;
      cnt_q       <= 4'd0;
      tag_q       <= 4'd0;
      type_q      <= 2'b00;
      bypass_q    <= 1'b0;
      vld_q       <= 1'b0;
      sop_q       <= 1'b0;
      eop_q       <= 1'b0;
      ptype_q     <= 2'b00;
      pbyp_q      <= 1'b0;
      data_q      <= '0;
      be_q        <= '0;
      perr_q      <= 1'b0;
      ack_q       <= 1'b0;
      ack_tag_q   <= 4'd0;
      proto_q     <= 1'b0;
      perr_cnt_q  <= '0;
      proto_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tag_q       <= tag_d;
      type_q      <= type_d;
      bypass_q    <= bypass_d;
      vld_q       <= vld_d;
      sop_q       <= sop_d;
      eop_q       <= eop_d;
      ptype_q     <= ptype_d;
      pbyp_q      <= pbyp_d;
      data_q      <= data_d;
      be_q        <= be_d;
      perr_q      <= perr_d;
      ack_q       <= ack_d;
      ack_tag_q   <= ack_tag_d;
      proto_q     <= proto_d;
      perr_cnt_q  <= perr_cnt_d;
      proto_cnt_q <= proto_cnt_d;
    end
  end

  assign pkt_vld           = vld_q;
  assign pkt_sop           = sop_q;
  assign pkt_eop           = eop_q;
  assign pkt_type          = ptype_q;
  assign pkt_bypass        = pbyp_q;
  assign pkt_data          = data_q;
  assign pkt_be            = be_q;
  assign pkt_perr          = perr_q;
  assign sii_dmu_wrack_vld = ack_q;
  assign sii_dmu_wrack_tag = ack_tag_q;
  assign proto_err         = proto_q;
  assign perr_cnt          = perr_cnt_q;
  assign proto_err_cnt     = proto_cnt_q;

endmodule

// File: tb/tb_sii_dmu_inbound_rx.sv
// Testbench for sii_dmu_inbound_rx: directed packets with literal expectations,
// then randomized cycles, all compared every cycle against a behavioural model.

module tb_sii_dmu_inbound_rx;

  localparam int WR = 4;
  localparam int MP = 1;

  logic         iol2clk = 1'b0;
  logic         rst_l   = 1'b0;
  logic         dmu_sii_hdr_vld = 1'b0, dmu_sii_reqbypass = 1'b0;
  logic         dmu_sii_datareq = 1'b0, dmu_sii_datareq16 = 1'b0;
  logic [127:0] dmu_sii_data = '0;
  logic [7:0]   dmu_sii_parity = '0;
  logic [15:0]  dmu_sii_be = '0;
  logic         pkt_vld, pkt_sop, pkt_eop, pkt_bypass, pkt_perr;
  logic [1:0]   pkt_type;
  logic [127:0] pkt_data;
  logic [15:0]  pkt_be;
  logic         sii_dmu_wrack_vld, proto_err;
  logic [3:0]   sii_dmu_wrack_tag;
  logic [15:0]  perr_cnt, proto_err_cnt;

  int checks = 0;
  int errors = 0;

  sii_dmu_inbound_rx #(
    .WR_BEATS(WR), .MP_BEATS(MP), .TAG_LSB(64), .ERRCNT_W(16)
  ) dut (
    .iol2clk(iol2clk), .rst_l(rst_l),
    .dmu_sii_hdr_vld(dmu_sii_hdr_vld), .dmu_sii_reqbypass(dmu_sii_reqbypass),
    .dmu_sii_datareq(dmu_sii_datareq), .dmu_sii_datareq16(dmu_sii_datareq16),
    .dmu_sii_data(dmu_sii_data), .dmu_sii_parity(dmu_sii_parity), .dmu_sii_be(dmu_sii_be),
    .pkt_vld(pkt_vld), .pkt_sop(pkt_sop), .pkt_eop(pkt_eop), .pkt_type(pkt_type),
    .pkt_bypass(pkt_bypass), .pkt_data(pkt_data), .pkt_be(pkt_be), .pkt_perr(pkt_perr),
    .sii_dmu_wrack_vld(sii_dmu_wrack_vld), .sii_dmu_wrack_tag(sii_dmu_wrack_tag),
    .proto_err(proto_err), .perr_cnt(perr_cnt), .proto_err_cnt(proto_err_cnt)
  );

  always #5 iol2clk = ~iol2clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] par_of(input logic [127:0] d);
    logic [7:0] p;
    for (int i = 0; i < 8; i++) p[i] = ^d[16*i +: 16];
    return p;
  endfunction

  // ---------------- behavioural model ----------------
  // Expected outputs for the cycle after each accepted input cycle.
  logic         e_vld = 0, e_sop = 0, e_eop = 0, e_byp = 0, e_perr = 0;
  logic [1:0]   e_type = 0;
  logic [127:0] e_data = 0;
  logic [15:0]  e_be = 0;
  logic         e_ack = 0, e_proto = 0;
  logic [3:0]   e_tag = 0;
  int           e_perr_n = 0, e_proto_n = 0;
  int           m_rem = 0;
  logic [1:0]   m_type = 0;
  logic         m_byp = 0;
  logic [3:0]   m_tag = 0;

  always @(posedge iol2clk or negedge rst_l) begin : model
    logic pe;
    if (!rst_l) begin
      e_vld = 0; e_sop = 0; e_eop = 0; e_byp = 0; e_perr = 0; e_type = 0;
      e_data = 0; e_be = 0; e_ack = 0; e_proto = 0; e_tag = 0;
      e_perr_n = 0; e_proto_n = 0; m_rem = 0;
    end else begin
      pe = (dmu_sii_parity != par_of(dmu_sii_data));
      // Ack for a write whose eop beat is currently on the outputs.
      e_ack = e_vld && e_eop && (e_type == 2'b01);
      e_tag = e_ack ? m_tag : 4'd0;
      e_vld = 0; e_sop = 0; e_eop = 0; e_proto = 0;
      if (m_rem > 0) begin
        e_vld = 1; e_type = m_type; e_byp = m_byp; e_data = dmu_sii_data;
        e_be = m_type[1] ? 16'hFFFF : dmu_sii_be;
        e_perr = pe; e_proto = dmu_sii_hdr_vld;
        m_rem--;
        e_eop = (m_rem == 0);
      end else if (dmu_sii_hdr_vld) begin
        if (!dmu_sii_datareq && dmu_sii_datareq16) begin
          e_proto = 1;
        end else begin
          e_vld = 1; e_sop = 1; e_byp = dmu_sii_reqbypass; e_data = dmu_sii_data;
          e_be = 16'hFFFF; e_perr = pe;
          if (!dmu_sii_datareq) begin
            e_type = 2'b00; e_eop = 1;
          end else if (!dmu_sii_datareq16) begin
            e_type = 2'b01; m_rem = WR; m_tag = dmu_sii_data[67:64];
          end else begin
            e_type = {1'b1, dmu_sii_reqbypass}; m_rem = MP;
          end
          m_type = e_type; m_byp = e_byp;
        end
      end
      if (e_vld && e_perr && e_perr_n < 65535) e_perr_n++;
      if (e_proto && e_proto_n < 65535) e_proto_n++;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge iol2clk) begin
    chk("vld", pkt_vld, e_vld);
    chk("ack", sii_dmu_wrack_vld, e_ack);
    chk("proto", proto_err, e_proto);
    chk("perr_cnt", perr_cnt, e_perr_n[15:0]);
    chk("proto_cnt", proto_err_cnt, e_proto_n[15:0]);
    if (e_ack) chk("ack_tag", sii_dmu_wrack_tag, e_tag);
    if (e_vld) begin
      chk("sop", pkt_sop, e_sop);
      chk("eop", pkt_eop, e_eop);
      chk("type", pkt_type, e_type);
      chk("bypass", pkt_bypass, e_byp);
      chk("data", pkt_data, e_data);
      chk("be", pkt_be, e_be);
      chk("perr", pkt_perr, e_perr);
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic hv, input logic byp, input logic dr, input logic dr16,
                       input logic [127:0] d, input logic [15:0] be, input logic [7:0] flip);
    dmu_sii_hdr_vld   = hv;
    dmu_sii_reqbypass = byp;
    dmu_sii_datareq   = dr;
    dmu_sii_datareq16 = dr16;
    dmu_sii_data      = d;
    dmu_sii_be        = be;
    dmu_sii_parity    = par_of(d) ^ flip;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic step();
    @(negedge iol2clk);
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  logic [15:0]  wbe [4] = '{16'hFFFF, 16'h00FF, 16'hFFFF, 16'hF000};
  logic [127:0] d;

  initial begin
    idle();
    step(); step();
    chk("rst_vld", pkt_vld, 1'b0);
    chk("rst_ack", sii_dmu_wrack_vld, 1'b0);
    chk("rst_perr_cnt", perr_cnt, 16'd0);
    #2 rst_l = 1'b1;
    step();

    // Read
    drive(1, 1, 0, 0, 128'h12_3456_7880, 16'h0, 8'h0);
    step();
    chk("rd_sop_eop", {pkt_vld, pkt_sop, pkt_eop}, 3'b111);
    chk("rd_type", pkt_type, 2'b00);
    chk("rd_bypass", pkt_bypass, 1'b1);
    chk("rd_data", pkt_data, 128'h12_3456_7880);
    idle(); step();
    chk("rd_no_ack", sii_dmu_wrack_vld, 1'b0);

    // Write, tag 0xA
    d = rnd128(); d[67:64] = 4'hA;
    drive(1, 0, 1, 0, d, 16'h0, 8'h0);
    step();
    chk("wr_sop", {pkt_vld, pkt_sop, pkt_eop}, 3'b110);
    chk("wr_type", pkt_type, 2'b01);
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, rnd128(), wbe[i], 8'h0);
      step();
      chk("wr_be", pkt_be, wbe[i]);
      chk("wr_eop", pkt_eop, (i == 3));
    end
    idle(); step();
    chk("wr_ack", {sii_dmu_wrack_vld, sii_dmu_wrack_tag}, 5'h1A);

    // Mondo then PIO read return
    for (int k = 0; k < 2; k++) begin
      drive(1, k[0], 1, 1, rnd128(), 16'h0, 8'h0);
      step();
      chk("mp_sop", {pkt_sop, pkt_eop, pkt_type}, {2'b10, 1'b1, k[0]});
      drive(0, 0, 0, 0, rnd128(), 16'h1234, 8'h0);
      step();
      chk("mp_eop", {pkt_vld, pkt_sop, pkt_eop, pkt_type}, {3'b101, 1'b1, k[0]});
      chk("mp_be", pkt_be, 16'hFFFF);
    end
    idle(); step();
    chk("mp_no_ack", sii_dmu_wrack_vld, 1'b0);

    // Parity error on write payload beat 2
    d = '0; d[67:64] = 4'h5;
    drive(1, 0, 1, 0, d, 16'h0, 8'h0);
    step();
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, rnd128(), 16'hFFFF, (i == 1) ? 8'h08 : 8'h00);
      step();
      chk("par_beat", pkt_perr, (i == 1));
    end
    chk("par_cnt", perr_cnt, 16'd1);
    idle(); step();
    chk("par_ack", {sii_dmu_wrack_vld, sii_dmu_wrack_tag}, 5'h15);

    // Header during write beat 3, then an illegal class
    d = '0; d[67:64] = 4'h3;
    drive(1, 0, 1, 0, d, 16'h0, 8'h0);
    step();
    for (int i = 0; i < 4; i++) begin
      drive((i == 2), 0, 1, 0, rnd128(), 16'hFFFF, 8'h0);
      step();
      chk("pr_beat", {pkt_vld, pkt_sop, pkt_eop}, {2'b10, (i == 3)});
      chk("pr_pulse", proto_err, (i == 2));
    end
    chk("pr_cnt1", proto_err_cnt, 16'd1);
    drive(1, 0, 0, 1, rnd128(), 16'h0, 8'h0);
    step();
    chk("ill_ack", {sii_dmu_wrack_vld, sii_dmu_wrack_tag}, 5'h13);
    chk("ill_novld", pkt_vld, 1'b0);
    chk("ill_pulse", proto_err, 1'b1);
    chk("ill_cnt", proto_err_cnt, 16'd2);
    idle(); step();

    // Reset mid-write
    d = '0; d[67:64] = 4'h7;
    drive(1, 0, 1, 0, d, 16'h0, 8'h0);
    step();
    drive(0, 0, 0, 0, rnd128(), 16'hFFFF, 8'h0);
    step();
    drive(0, 0, 0, 0, rnd128(), 16'hFFFF, 8'h0);
    #2 rst_l = 1'b0;
    #1;
    chk("ar_vld", pkt_vld, 1'b0);
    chk("ar_cnt", {perr_cnt, proto_err_cnt}, 32'h0);
    idle();
    step(); step();
    #2 rst_l = 1'b1;
    step();
    drive(1, 0, 0, 0, 128'hBEEF, 16'h0, 8'h0);
    step();
    chk("ar_rd", {pkt_vld, pkt_sop, pkt_eop, pkt_type}, 5'b11100);
    idle(); step();
    chk("ar_no_ack", sii_dmu_wrack_vld, 1'b0);
    step();

    // Randomized cycles
    for (int n = 0; n < 1500; n++) begin
      drive(($urandom_range(0, 2) == 0), $urandom_range(0, 1), $urandom_range(0, 1),
            $urandom_range(0, 1), rnd128(), 16'($urandom),
            ($urandom_range(0, 7) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h0);
      step();
    end
    idle();
    repeat (8) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
